// File: rtl/rr_reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit holding register.
// Requesters compete in IDLE. The winner is granted for one BUSY cycle. Its
// data is sampled in that cycle and loaded into Q, together with a one-cycle
// ACK. CLR clears Q and drops any pending grant. It has priority over
// everything except RESET_N.
module rr_reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*WIDTH-1:0] DATA_IN,
  input  logic                     CLR,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [IDX_W-1:0]         OWNER,
  output logic                     ACK,
  output logic [WIDTH-1:0]         Q,
  output logic                     Q_VALID
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;

  // grant stage (p0) and commit stage (p1) registers
  logic [NUM_REQ-1:0] gnt_p0;
  logic [IDX_W-1:0]   owner_p0;
  logic [WIDTH-1:0]   q_p1;
  logic               ack_p1;
  logic               q_valid_p1;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   ptr_next;

  // Unpack the flat data bus into one slice per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = DATA_IN[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search starting at ptr. The loop runs from the far end back
  // to ptr, so the candidate closest to ptr is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  // Pointer moves just past the owner of a committed write
  assign ptr_next = (owner_p0 == IDX_W'(NUM_REQ - 1)) ? '0 : owner_p0 + IDX_W'(1);

  // Control FSM plus the shared register. CLR is checked first so it beats a
  // commit in the same cycle. ack_p1 defaults low, which gives a single-cycle pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_p0     <= '0;
      owner_p0   <= '0;
      q_p1       <= '0;
      ack_p1     <= 1'b0;
      q_valid_p1 <= 1'b0;
    end else begin
      ack_p1 <= 1'b0;
      if (CLR) begin
        state      <= IDLE;
        gnt_p0     <= '0;
        q_p1       <= '0;
        q_valid_p1 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (win_found) begin
              gnt_p0   <= win_onehot;
              owner_p0 <= win_idx;
              state    <= BUSY;
            end else begin
              gnt_p0 <= '0;
            end
          end
          BUSY: begin
            gnt_p0 <= '0;
            state  <= IDLE;
            if (REQ[owner_p0]) begin
              q_p1       <= data_arr[owner_p0];
              q_valid_p1 <= 1'b1;
              ack_p1     <= 1'b1;
              ptr        <= ptr_next;
            end
          end
          default: begin
            gnt_p0 <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign GNT     = gnt_p0;
  assign OWNER   = owner_p0;
  assign ACK     = ack_p1;
  assign Q       = q_p1;
  assign Q_VALID = q_valid_p1;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter (NUM_REQ=4, WIDTH=8).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_rr_reg_write_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  REQ;
  logic [31:0] DATA_IN;
  logic        CLR;
  logic [3:0]  GNT;
  logic [1:0]  OWNER;
  logic        ACK;
  logic [7:0]  Q;
  logic        Q_VALID;

  int total = 0;
  int bad   = 0;

  rr_reg_write_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (8),
    .IDX_W  (2)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .REQ    (REQ),
    .DATA_IN(DATA_IN),
    .CLR    (CLR),
    .GNT    (GNT),
    .OWNER  (OWNER),
    .ACK    (ACK),
    .Q      (Q),
    .Q_VALID(Q_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    CLR     = 1'b0;
    REQ     = 4'b1111;
    DATA_IN = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    tick();
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want %b", GNT, 4'b0000); end
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL rst_q: got %h want %h", Q, 8'h00); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL rst_qv: got %b want 0", Q_VALID); end
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", ACK); end
    total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", OWNER); end
    RESET_N = 1'b1;
    tick();
    total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL rst_rel_gnt: got %b want %b", GNT, 4'b0001); end
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL rst_rel_ack0: got %b want 0", ACK); end
    tick();
    total++; if (Q !== 8'h11) begin bad++; $display("FAIL rst_rel_q: got %h want %h", Q, 8'h11); end
    total++; if (ACK !== 1'b1) begin bad++; $display("FAIL rst_rel_ack: got %b want 1", ACK); end
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_rel_gnt0: got %b want 0000", GNT); end
    REQ = 4'b0000;
    tick();
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL rst_ack_pulse: got %b want 0", ACK); end
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_idle_gnt: got %b want 0000", GNT); end
  endtask

  // The pointer is 1 on entry
  task automatic test_single();
    DATA_IN = {8'h44, 8'hA5, 8'h22, 8'h11};
    REQ     = 4'b0100;
    tick();
    total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want %b", GNT, 4'b0100); end
    total++; if (OWNER !== 2'd2) begin bad++; $display("FAIL single_owner: got %0d want 2", OWNER); end
    tick();
    total++; if (Q !== 8'hA5) begin bad++; $display("FAIL single_q: got %h want %h", Q, 8'hA5); end
    total++; if (ACK !== 1'b1) begin bad++; $display("FAIL single_ack: got %b want 1", ACK); end
    total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL single_qv: got %b want 1", Q_VALID); end
    REQ = 4'b0000;
    tick();
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL single_ack_pulse: got %b want 0", ACK); end
    total++; if (Q !== 8'hA5) begin bad++; $display("FAIL single_q_hold: got %h want %h", Q, 8'hA5); end
    // With the pointer at 3, requester 3 beats requester 0
    REQ = 4'b1001;
    tick();
    total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL single_ptr_gnt: got %b want %b", GNT, 4'b1000); end
    total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL single_ptr_owner: got %0d want 3", OWNER); end
    tick();
    total++; if (Q !== 8'h44) begin bad++; $display("FAIL single_ptr_q: got %h want %h", Q, 8'h44); end
    REQ = 4'b0000;
    tick();
  endtask

  // The pointer is 0 on entry
  task automatic test_back_to_back();
    logic [7:0] dv [4];
    logic [3:0] oh;
    dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
    DATA_IN = {dv[3], dv[2], dv[1], dv[0]};
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      total++; if (GNT !== oh) begin bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, GNT, oh); end
      total++; if (OWNER !== 2'(k % 4)) begin bad++; $display("FAIL b2b_owner[%0d]: got %0d want %0d", k, OWNER, k % 4); end
      total++; if (ACK !== 1'b0) begin bad++; $display("FAIL b2b_ack_gap[%0d]: got %b want 0", k, ACK); end
      REQ = 4'b1111;
      tick();
      total++; if (ACK !== 1'b1) begin bad++; $display("FAIL b2b_ack[%0d]: got %b want 1", k, ACK); end
      total++; if (Q !== dv[k % 4]) begin bad++; $display("FAIL b2b_q[%0d]: got %h want %h", k, Q, dv[k % 4]); end
      REQ = 4'b1111 & ~oh;
    end
    REQ = 4'b0000;
    tick();
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL b2b_end_gnt: got %b want 0000", GNT); end
  endtask

  // The pointer is 1 and Q is 8'h10 on entry
  task automatic test_abort();
    REQ = 4'b0010;
    tick();
    total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL abort_gnt: got %b want %b", GNT, 4'b0010); end
    REQ = 4'b0000;
    tick();
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL abort_gnt0: got %b want 0000", GNT); end
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b want 0", ACK); end
    total++; if (Q !== 8'h10) begin bad++; $display("FAIL abort_q: got %h want %h", Q, 8'h10); end
    // The pointer must still be 1, so requester 1 beats requester 0
    REQ = 4'b0011;
    tick();
    total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL abort_ptr_gnt: got %b want %b", GNT, 4'b0010); end
    tick();
    total++; if (Q !== 8'h21) begin bad++; $display("FAIL abort_commit_q: got %h want %h", Q, 8'h21); end
    REQ = 4'b0000;
    tick();
  endtask

  // The pointer is 2 on entry
  task automatic test_clear();
    DATA_IN = {8'h3C, 8'h32, 8'h21, 8'h10};
    REQ = 4'b1000;
    tick();
    tick();
    total++; if (Q !== 8'h3C) begin bad++; $display("FAIL clr_setup_q: got %h want %h", Q, 8'h3C); end
    REQ = 4'b0000;
    tick();
    REQ = 4'b1000;
    tick();
    total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL clr_busy_gnt: got %b want %b", GNT, 4'b1000); end
    CLR = 1'b1;
    DATA_IN = {8'h77, 8'h32, 8'h21, 8'h10};
    tick();
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL clr_q: got %h want %h", Q, 8'h00); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL clr_qv: got %b want 0", Q_VALID); end
    total++; if (ACK !== 1'b0) begin bad++; $display("FAIL clr_ack: got %b want 0", ACK); end
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL clr_gnt: got %b want 0000", GNT); end
    CLR = 1'b0;
    tick();
    total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL clr_regnt: got %b want %b", GNT, 4'b1000); end
    tick();
    total++; if (ACK !== 1'b1) begin bad++; $display("FAIL clr_regnt_ack: got %b want 1", ACK); end
    total++; if (Q !== 8'h77) begin bad++; $display("FAIL clr_regnt_q: got %h want %h", Q, 8'h77); end
    total++; if (Q_VALID !== 1'b1) begin bad++; $display("FAIL clr_regnt_qv: got %b want 1", Q_VALID); end
    REQ = 4'b0000;
    tick();
  endtask

  // The pointer is 0 on entry
  task automatic test_async_reset();
    REQ = 4'b0010;
    tick();
    tick();
    REQ = 4'b0000;
    tick();
    // The pointer is now 2, so all-request grants requester 2
    REQ = 4'b1111;
    tick();
    total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL arst_pre_gnt: got %b want %b", GNT, 4'b0100); end
    #3;
    RESET_N = 1'b0;
    #1;
    total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL arst_gnt: got %b want 0000", GNT); end
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL arst_q: got %h want %h", Q, 8'h00); end
    total++; if (Q_VALID !== 1'b0) begin bad++; $display("FAIL arst_qv: got %b want 0", Q_VALID); end
    total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL arst_owner: got %0d want 0", OWNER); end
    #1;
    RESET_N = 1'b1;
    tick();
    total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL arst_restart_gnt: got %b want %b", GNT, 4'b0001); end
    tick();
    total++; if (Q !== 8'h10) begin bad++; $display("FAIL arst_restart_q: got %h want %h", Q, 8'h10); end
    total++; if (ACK !== 1'b1) begin bad++; $display("FAIL arst_restart_ack: got %b want 1", ACK); end
    REQ = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
